// File: rtl/popcount_scheduler.sv
// Round-robin scheduler sharing one popcount datapath between NREQ requesters.
// Each granted frame's set-bit total is returned with the requester id, saturating at 2^CW-1.
module popcount_scheduler #(
  parameter  int WIDTH    = 8,
  parameter  int NREQ     = 4,
  parameter  int MAXWORDS = 16,
  localparam int CW       = $clog2(WIDTH*MAXWORDS+1),
  localparam int IW       = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IW-1:0]         res_id,
  output logic [CW-1:0]         res_count,
  output logic                  res_sat
);

  localparam int PW = $clog2(WIDTH+1);
  localparam int SW = CW + 1;
  localparam logic [CW-1:0] CMAX = '1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_BUSY   = 2'd1;
  localparam logic [1:0] S_RESULT = 2'd2;

  logic [1:0]    r_state;
  logic [IW-1:0] r_grant;
  logic [IW-1:0] r_last_grant;
  logic [CW-1:0] r_acc;
  logic          r_sat;
  logic [CW-1:0] r_res_count;
  logic [IW-1:0] r_res_id;
  logic          r_res_sat;

  logic          w_any;
  logic [IW-1:0] w_pick;
  int            w_idx;
  logic [WIDTH-1:0] w_word;
  logic [PW-1:0] w_pop;
  logic [SW-1:0] w_sum;
  logic [CW-1:0] w_acc_next;
  logic          w_sat_next;
  logic          w_beat;

  // Scan downward so the nearest requester after last_grant is assigned last and wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = 0;
    for (int k = NREQ; k >= 1; k--) begin
      w_idx = (int'(r_last_grant) + k) % NREQ;
      if (req_valid[w_idx]) begin
        w_any  = 1'b1;
        w_pick = IW'(w_idx);
      end
    end
  end

  assign w_word = req_data[r_grant*WIDTH +: WIDTH];
  assign w_beat = (r_state == S_BUSY) && req_valid[r_grant];

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + PW'(w_word[i]);
    end
  end

  // The carry out of the widened sum is exactly the "exceeds 2^CW-1" condition.
  always_comb begin
    w_sum      = {1'b0, r_acc} + SW'(w_pop);
    w_acc_next = w_sum[CW-1:0];
    w_sat_next = r_sat;
    if (w_sum[CW]) begin
      w_acc_next = CMAX;
      w_sat_next = 1'b1;
    end
  end

  assign req_ready = (r_state == S_BUSY) ? (NREQ'(1) << r_grant) : '0;
  assign res_valid = (r_state == S_RESULT);
  assign res_id    = r_res_id;
  assign res_count = r_res_count;
  assign res_sat   = r_res_sat;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_grant      <= '0;
      r_last_grant <= IW'(NREQ-1);
      r_acc        <= '0;
      r_sat        <= 1'b0;
      r_res_count  <= '0;
      r_res_id     <= '0;
      r_res_sat    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_beat) begin
            r_acc <= w_acc_next;
            r_sat <= w_sat_next;
            if (req_last[r_grant]) begin
              r_res_count <= w_acc_next;
              r_res_sat   <= w_sat_next;
              r_res_id    <= r_grant;
              r_state     <= S_RESULT;
            end
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            r_last_grant <= r_grant;
            r_state      <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_popcount_scheduler.sv
// Scoreboard bench for popcount_scheduler: drivers push expected results on the last beat,
// a negedge monitor compares every presented result against the queue head.
module tb_popcount_scheduler;

  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int MAXW  = 4;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [1:0]        res_id;
  logic [5:0]        res_count;
  logic              res_sat;

  logic       tb_v [NREQ];
  logic [7:0] tb_d [NREQ];
  logic       tb_l [NREQ];

  typedef struct {
    logic [1:0] id;
    logic [5:0] count;
    logic       sat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  popcount_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ), .MAXWORDS(MAXW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_count (res_count),
    .res_sat   (res_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = tb_v[i];
      req_last[i]          = tb_l[i];
      req_data[i*8 +: 8]   = tb_d[i];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Words are packed low-first in w. With finish=0 the frame never sends last and pushes nothing.
  task automatic send_frame(input int id, input logic [63:0] w, input int n, input bit finish,
                            input int exp_count, input bit exp_sat,
                            input int gap_at, input int gap_len, output int wait0);
    int  budget;
    bit  ok;
    wait0 = 0;
    for (int k = 0; k < n; k++) begin
      budget   = 0;
      ok       = 1'b0;
      tb_v[id] = 1'b1;
      tb_d[id] = w[k*8 +: 8];
      tb_l[id] = finish && (k == n-1);
      while (!ok && budget < 200) begin
        @(negedge clk);
        if (req_ready[id]) ok = 1'b1;
        else begin
          budget++;
          if (k == 0) wait0++;
        end
      end
      if (!ok) begin
        check($sformatf("ready_timeout_req%0d", id), 32'd0, 32'd1);
        tb_v[id] = 1'b0;
        tb_l[id] = 1'b0;
        return;
      end
      if (finish && k == n-1) sb.push_back('{2'(id), 6'(exp_count), exp_sat});
      tick();
      if (k == gap_at) begin
        tb_v[id] = 1'b0;
        repeat (gap_len) tick();
      end
    end
    tb_v[id] = 1'b0;
    tb_l[id] = 1'b0;
  endtask

  // Monitor: every cycle a result is presented it must match the queue head exactly.
  always @(negedge clk) begin
    if (!rst && res_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        check("res_id",    32'(res_id),    32'(sb[0].id));
        check("res_count", 32'(res_count), 32'(sb[0].count));
        check("res_sat",   32'(res_sat),   32'(sb[0].sat));
        check("ready_in_result", 32'(req_ready), 32'd0);
        if (res_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int w0, w1, w3, w0b;
    for (int i = 0; i < NREQ; i++) begin
      tb_v[i] = 1'b0;
      tb_d[i] = 8'h00;
      tb_l[i] = 1'b0;
    end
    res_ready = 1'b1;
    rst       = 1'b1;
    tick();
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_count", 32'(res_count), 32'd0);
    check("rst_res_id",    32'(res_id),    32'd0);
    check("rst_res_sat",   32'(res_sat),   32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    // 1. Single requester: 0xFF,0x0F,0x01 -> 13
    send_frame(2, 64'h01_0F_FF, 3, 1'b1, 13, 1'b0, -1, 0, w0);
    check("t1_grant_latency", 32'(w0), 32'd1);
    @(negedge clk);
    check("t1_res_valid_after_last", 32'(res_valid), 32'd1);
    tick();
    tick();

    // 2. Contention: 0,1,3 then 0 re-requests; expected order 0,1,3,0
    do_reset();
    fork
      begin
        send_frame(0, 64'h03, 1, 1'b1, 2, 1'b0, -1, 0, w0);
        send_frame(0, 64'h03, 1, 1'b1, 2, 1'b0, -1, 0, w0b);
      end
      send_frame(1, 64'h03, 1, 1'b1, 2, 1'b0, -1, 0, w1);
      send_frame(3, 64'h03, 1, 1'b1, 2, 1'b0, -1, 0, w3);
    join
    check("t2_req0_first_grant", 32'(w0), 32'd1);
    tick();
    tick();
    check("t2_sb_drained", 32'(sb.size()), 32'd0);

    // 3. Saturation: 8 x 0xFF -> 63 sat, then 0x01 -> 1 clean
    send_frame(1, 64'hFFFF_FFFF_FFFF_FFFF, 8, 1'b1, 63, 1'b1, -1, 0, w1);
    send_frame(1, 64'h01, 1, 1'b1, 1, 1'b0, -1, 0, w1);
    tick();
    tick();

    // 4. Bubbles (3 idle cycles after first word) and 5 cycles of result backpressure
    res_ready = 1'b0;
    send_frame(0, 64'hF0_7E_81, 3, 1'b1, 12, 1'b0, 0, 3, w0);
    repeat (5) begin
      @(negedge clk);
      check("t4_stall_valid", 32'(res_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    tick();
    @(negedge clk);
    check("t4_released", 32'(res_valid), 32'd0);
    tick();

    // 5. Reset after 2 beats: no result; then requester 0 wins over 1
    send_frame(2, 64'hFF_FF, 2, 1'b0, 0, 1'b0, -1, 0, w0);
    rst = 1'b1;
    #1;
    check("t5_rst_ready", 32'(req_ready), 32'd0);
    check("t5_rst_valid", 32'(res_valid), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    fork
      send_frame(0, 64'hAA, 1, 1'b1, 4, 1'b0, -1, 0, w0);
      send_frame(1, 64'h01, 1, 1'b1, 1, 1'b0, -1, 0, w1);
    join
    check("t5_req0_wins", 32'(w0), 32'd1);
    repeat (3) tick();
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
